// File: rtl/univ_shift_reg_n_if.sv
// Bus interface for univ_shift_reg_n: the request side (start/mode/amt/d
// plus live serial inputs) and the register/status side (q, serial outs,
// busy/done and the FSM debug view).
//
// Handshake: a request is taken on a rising edge where start=1 and the
// engine is idle (busy=0); the requester may hold or pulse start. While
// busy=1 start is ignored, never queued. done is a one-cycle completion
// pulse, never high together with busy, and the done cycle already
// accepts a new start.
interface univ_shift_reg_n_if #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
);
   logic             start;
   logic [2:0]       mode;
   logic [AMT_W-1:0] amt;
   logic [WIDTH-1:0] d;
   logic             msb_in;
   logic             lsb_in;
   logic [WIDTH-1:0] q;
   logic             so_lsb;
   logic             so_msb;
   logic             busy;
   logic             done;
   logic             state_dbg;   // 0 = IDLE, 1 = RUN
   logic [AMT_W-1:0] count_dbg;   // remaining steps

   modport master (
      output start, mode, amt, d, msb_in, lsb_in,
      input  q, so_lsb, so_msb, busy, done, state_dbg, count_dbg
   );

   modport slave (
      input  start, mode, amt, d, msb_in, lsb_in,
      output q, so_lsb, so_msb, busy, done, state_dbg, count_dbg
   );
endinterface

// File: rtl/univ_shift_reg_n.sv
// Universal shift register with a multi-cycle shift engine. Hold, load and
// clear complete on the accept edge; shifts and rotates advance one bit per
// clock for the captured count, then pulse done.
module univ_shift_reg_n #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input logic               clk,
   input logic               clear,   // asynchronous, active low
   univ_shift_reg_n_if.slave bus
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam logic [2:0]       MODE_HOLD  = 3'b000;
   localparam logic [2:0]       MODE_SRL   = 3'b001;
   localparam logic [2:0]       MODE_SLL   = 3'b010;
   localparam logic [2:0]       MODE_LOAD  = 3'b011;
   localparam logic [2:0]       MODE_ROR   = 3'b100;
   localparam logic [2:0]       MODE_ROL   = 3'b101;
   localparam logic [2:0]       MODE_SRA   = 3'b110;
   localparam logic [2:0]       MODE_CLR   = 3'b111;
   localparam logic [AMT_W-1:0] CNT_ONE    = {{(AMT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   logic [WIDTH-1:0] r_q;
   logic [AMT_W-1:0] r_count;
   logic [2:0]       r_mode;
   logic             r_done;

   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_q_nxt;
   logic [AMT_W-1:0] w_count_nxt;
   logic [2:0]       w_mode_nxt;
   logic             w_done_nxt;
   logic             w_immediate;

   // One step of a shift/rotate mode; non-stepping modes leave the value.
   function automatic logic [WIDTH-1:0] f_step(
      input logic [2:0]       m,
      input logic [WIDTH-1:0] v,
      input logic             si_r,
      input logic             si_l
   );
      logic [WIDTH-1:0] res;
      res = v;
      case (m)
         MODE_SRL: res = {si_r, v[WIDTH-1:1]};
         MODE_SLL: res = {v[WIDTH-2:0], si_l};
         MODE_ROR: res = {v[0], v[WIDTH-1:1]};
         MODE_ROL: res = {v[WIDTH-2:0], v[WIDTH-1]};
         MODE_SRA: res = {v[WIDTH-1], v[WIDTH-1:1]};
         default:  res = v;
      endcase
      return res;
   endfunction

   // Requests that finish on the accept edge: hold/load/clear or a zero count.
   assign w_immediate = (bus.mode == MODE_HOLD) || (bus.mode == MODE_LOAD) ||
                        (bus.mode == MODE_CLR)  || (bus.amt == '0);

   // Next-state, next-register and done-pulse logic.
   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_count_nxt = r_count;
      w_mode_nxt  = r_mode;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_mode_nxt  = bus.mode;
               w_count_nxt = bus.amt;
               if (w_immediate) begin
                  if (bus.mode == MODE_LOAD) begin
                     w_q_nxt = bus.d;
                  end else if (bus.mode == MODE_CLR) begin
                     w_q_nxt = '0;
                  end
                  w_done_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_RUN;
               end
            end
         end
         S_RUN: begin
            w_q_nxt     = f_step(r_mode, r_q, bus.msb_in, bus.lsb_in);
            w_count_nxt = r_count - CNT_ONE;
            if (r_count == CNT_ONE) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation silently.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         r_state <= S_IDLE;
         r_q     <= '0;
         r_count <= '0;
         r_mode  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_count <= w_count_nxt;
         r_mode  <= w_mode_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign bus.q         = r_q;
   assign bus.so_lsb    = r_q[0];
   assign bus.so_msb    = r_q[WIDTH-1];
   assign bus.busy      = (r_state == S_RUN);
   assign bus.done      = r_done;
   assign bus.state_dbg = (r_state == S_RUN);
   assign bus.count_dbg = r_count;

endmodule
